// File: rtl/reduction_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reduction_pkg
// Description : Shared FSM state type and default sizing for the reduction unit.
// Revision    : 1.0 - initial release
// ============================================================================
package reduction_pkg;

    localparam int C_ACCUM_WIDTH = 48;
    localparam int C_LANES       = 4;
    localparam int C_MAX_BEATS   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage : reduction_pkg
`default_nettype wire

// File: rtl/reduction_lane.sv
`default_nettype none
// ============================================================================
// Module      : reduction_lane
// Description : One lane: sparse combine, accumulate, saturate/wrap, sticky overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module reduction_lane
    import reduction_pkg::*;
#(
    parameter int ACCUM_WIDTH = C_ACCUM_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [ACCUM_WIDTH-1:0] i_lsp,
    input  logic [ACCUM_WIDTH-1:0] i_msp,
    input  logic                   i_sparse,
    input  logic                   i_accept,
    input  logic                   i_first,
    input  logic                   i_close,
    input  logic                   i_sat,
    output logic [ACCUM_WIDTH-1:0] o_result,
    output logic                   o_ovf
);

    localparam int W = ACCUM_WIDTH;

    logic [W-1:0] acc_q, acc_d;
    logic         ovf_q, ovf_d;
    logic [W-1:0] res_q, res_d;
    logic         res_ovf_q, res_ovf_d;

    logic [W:0]   w_comb_x;
    logic         w_comb_ovf;
    logic [W-1:0] w_beat;
    logic [W-1:0] w_base;
    logic [W:0]   w_sum_x;
    logic         w_sum_ovf;
    logic [W-1:0] w_res;
    logic         w_ovf_new;

    function automatic logic [W-1:0] clamp(input logic neg);
        return neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    endfunction

    // One guard bit: overflow shows as the top two bits disagreeing.
    always_comb begin
        w_comb_x   = {i_lsp[W-1], i_lsp} + (i_sparse ? {i_msp[W-1], i_msp} : {(W+1){1'b0}});
        w_comb_ovf = w_comb_x[W] ^ w_comb_x[W-1];
        w_beat     = (w_comb_ovf && i_sat) ? clamp(w_comb_x[W]) : w_comb_x[W-1:0];
        w_base     = i_first ? {W{1'b0}} : acc_q;
        w_sum_x    = {w_base[W-1], w_base} + {w_beat[W-1], w_beat};
        w_sum_ovf  = w_sum_x[W] ^ w_sum_x[W-1];
        w_res      = (w_sum_ovf && i_sat) ? clamp(w_sum_x[W]) : w_sum_x[W-1:0];
        w_ovf_new  = w_comb_ovf | w_sum_ovf | (~i_first & ovf_q);
    end

    always_comb begin
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        res_d     = res_q;
        res_ovf_d = res_ovf_q;
        if (i_accept) begin
            if (i_close) begin
                res_d     = w_res;
                res_ovf_d = w_ovf_new;
            end else begin
                acc_d = w_res;
                ovf_d = w_ovf_new;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            res_q     <= '0;
            res_ovf_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            res_q     <= res_d;
            res_ovf_q <= res_ovf_d;
        end
    end

    assign o_result = res_q;
    assign o_ovf    = res_ovf_q;

endmodule : reduction_lane
`default_nettype wire

// File: rtl/reduction_accum_unit.sv
`default_nettype none
// ============================================================================
// Module      : reduction_accum_unit
// Description : Multi-lane group reduction with shared FSM, beat counter and output hold.
// Revision    : 1.0 - initial release
// ============================================================================
module reduction_accum_unit
    import reduction_pkg::*;
#(
    parameter int ACCUM_WIDTH = C_ACCUM_WIDTH,
    parameter int LANES       = C_LANES,
    parameter int MAX_BEATS   = C_MAX_BEATS,
    parameter int CNT_W       = $clog2(MAX_BEATS + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [LANES*ACCUM_WIDTH-1:0] in_data,
    input  logic [LANES*ACCUM_WIDTH-1:0] in_msp,
    input  logic                         in_sparse,
    input  logic                         in_last,
    input  logic                         acc_en,
    input  logic                         sat_en,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LANES*ACCUM_WIDTH-1:0] out_data,
    output logic [LANES-1:0]             out_ovf,
    output logic [CNT_W-1:0]             out_beats
);

    localparam logic [CNT_W-1:0] C_MAX_CNT = CNT_W'(MAX_BEATS);
    localparam logic [CNT_W-1:0] C_ONE     = CNT_W'(1);

    state_t           state_q, state_d;
    logic             acc_mode_q, acc_mode_d;
    logic             sat_mode_q, sat_mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] beats_q, beats_d;

    logic             w_accept;
    logic             w_first;
    logic             w_acc_eff;
    logic             w_sat_eff;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_close;

    // Mode bits come straight from the ports on a group's first beat, then from the latched copy.
    always_comb begin
        w_accept   = in_valid && in_ready;
        w_first    = (state_q != ST_ACCUM);
        w_acc_eff  = w_first ? acc_en : acc_mode_q;
        w_sat_eff  = w_first ? sat_en : sat_mode_q;
        w_cnt_next = w_first ? C_ONE : (cnt_q + C_ONE);
        w_close    = !w_acc_eff || in_last || (w_cnt_next == C_MAX_CNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (w_accept) begin
                    state_d = w_close ? ST_HOLD : ST_ACCUM;
                end
            end
            ST_HOLD: begin
                if (w_accept) begin
                    state_d = w_close ? ST_HOLD : ST_ACCUM;
                end else if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q != ST_HOLD) || out_ready;
        out_valid = (state_q == ST_HOLD);
    end

    always_comb begin
        acc_mode_d = acc_mode_q;
        sat_mode_d = sat_mode_q;
        cnt_d      = cnt_q;
        beats_d    = beats_q;
        if (w_accept) begin
            if (w_first) begin
                acc_mode_d = acc_en;
                sat_mode_d = sat_en;
            end
            cnt_d = w_close ? '0 : w_cnt_next;
            if (w_close) begin
                beats_d = w_cnt_next;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_mode_q <= 1'b0;
            sat_mode_q <= 1'b0;
            cnt_q      <= '0;
            beats_q    <= '0;
        end else begin
            acc_mode_q <= acc_mode_d;
            sat_mode_q <= sat_mode_d;
            cnt_q      <= cnt_d;
            beats_q    <= beats_d;
        end
    end

    assign out_beats = beats_q;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lanes
            reduction_lane #(
                .ACCUM_WIDTH (ACCUM_WIDTH)
            ) u_lane (
                .clk      (clk),
                .rst      (rst),
                .i_lsp    (in_data[gi*ACCUM_WIDTH +: ACCUM_WIDTH]),
                .i_msp    (in_msp[gi*ACCUM_WIDTH +: ACCUM_WIDTH]),
                .i_sparse (in_sparse),
                .i_accept (w_accept),
                .i_first  (w_first),
                .i_close  (w_close),
                .i_sat    (w_sat_eff),
                .o_result (out_data[gi*ACCUM_WIDTH +: ACCUM_WIDTH]),
                .o_ovf    (out_ovf[gi])
            );
        end
    endgenerate

endmodule : reduction_accum_unit
`default_nettype wire

// File: doc/reduction_accum_unit.md
REDUCTION_ACCUM_UNIT -- requirements
Module: reduction_accum_unit

Interface
REQ-001 The block SHALL have parameter ACCUM_WIDTH, default 48, giving the per-lane signed two's-complement width.
REQ-002 The block SHALL have parameter LANES, default 4, giving the number of independent reduction lanes.
REQ-003 The block SHALL have parameter MAX_BEATS, default 16, giving the maximum beats per group; CNT_W = clog2(MAX_BEATS+1).
REQ-004 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 The block SHALL have port in_valid, input, 1 bit: input beat valid.
REQ-008 The block SHALL have port in_ready, output, 1 bit: input beat accepted when in_valid && in_ready.
REQ-009 The block SHALL have port in_data, input, LANES*ACCUM_WIDTH bits: LSP per lane; lane i is bits [i*ACCUM_WIDTH +: ACCUM_WIDTH].
REQ-010 The block SHALL have port in_msp, input, LANES*ACCUM_WIDTH bits: MSP per lane, packed as in_data.
REQ-011 The block SHALL have port in_sparse, input, 1 bit: per-beat select to add MSP to LSP.
REQ-012 The block SHALL have port in_last, input, 1 bit: final beat of a group.
REQ-013 The block SHALL have port acc_en, input, 1 bit: 1 = accumulate over a group, 0 = per-beat pass mode.
REQ-014 The block SHALL have port sat_en, input, 1 bit: 1 = saturating arithmetic, 0 = wrap.
REQ-015 The block SHALL have port out_valid, output, 1 bit: result valid.
REQ-016 The block SHALL have port out_ready, input, 1 bit: result consumed when out_valid && out_ready.
REQ-017 The block SHALL have port out_data, output, LANES*ACCUM_WIDTH bits: result per lane.
REQ-018 The block SHALL have port out_ovf, output, LANES bits: per-lane sticky overflow flag for the group.
REQ-019 The block SHALL have port out_beats, output, CNT_W bits: number of beats in the reported group.

Function
REQ-020 Each lane SHALL form beat value v = in_sparse ? (lsp + msp) : lsp, using ACCUM_WIDTH+1 bit intermediate precision.
REQ-021 The block SHALL use FSM states IDLE (no group open), ACCUM (group open) and HOLD (result held in the output register).
REQ-022 acc_en and sat_en SHALL be sampled on the first accepted beat of a group and held until the group closes; changes mid-group SHALL be ignored.
REQ-023 In pass mode, every accepted beat SHALL go directly to HOLD with out_data = v, out_beats = 1 and out_valid asserted on the next cycle (latency 1).
REQ-024 In accumulate mode, the first beat SHALL load acc = v and each later beat SHALL set acc = acc + v.
REQ-025 The group SHALL close on an accepted beat with in_last = 1 or on the MAX_BEATS-th beat, whichever comes first; the result SHALL be registered with out_valid high on the next cycle.
REQ-026 A beat with in_last = 1 SHALL close a group even when it is the first beat (out_beats = 1).
REQ-027 Overflow of either the combine add or the accumulate add beyond ACCUM_WIDTH signed range SHALL set the lane's out_ovf bit, sticky until the group result is consumed.
REQ-028 When sat_en = 1, an overflowing result SHALL clamp to 2^(W-1)-1 or -2^(W-1); when sat_en = 0, it SHALL wrap modulo 2^W.
REQ-029 in_ready SHALL equal (state != HOLD) || out_ready, as a combinational function of the FSM state and out_ready.
REQ-030 On a simultaneous output handshake and input accept in HOLD, the block SHALL consume the result and start a new group in the same cycle, with no bubble.
REQ-031 out_data, out_ovf and out_beats SHALL stay stable while out_valid && !out_ready.
REQ-032 The block SHALL NOT issue out_valid for an open group that receives no further beats.

Reset
REQ-033 Asserting rst SHALL, asynchronously, set the FSM to IDLE, out_valid to 0, and out_data, out_ovf, out_beats, the accumulators and the beat counter to 0.
REQ-034 Reset asserted mid-group or during HOLD SHALL discard the partial or held result with no output.
REQ-035 in_ready SHALL be 1 on the first cycle after rst deasserts.

Structure
REQ-036 Package reduction_pkg SHALL hold the FSM state typedef and the default ACCUM_WIDTH, LANES and MAX_BEATS constants.
REQ-037 The per-lane combine, accumulate, saturate and overflow datapath SHALL be one sub-module, reduction_lane, instantiated LANES times; the FSM and the beat counter SHALL be shared by all lanes.

Verification (ACCUM_WIDTH=8, LANES=2, MAX_BEATS=4)
REQ-038 Pass mode: lane0 lsp=5, msp=3; sparse=1 then sparse=0 -> outputs 8 then 5, each 1 cycle after accept, out_beats=1.
REQ-039 Accumulate: beats 10, 20, 30 with the last beat flagged -> out_data=60, out_beats=3, out_valid exactly 1 cycle after the last beat.
REQ-040 Saturation: acc_en=1, sat_en=1, beats 100 + 100 -> lane0=127, out_ovf[0]=1; sat_en=0 -> lane0=-56, out_ovf[0]=1.
REQ-041 MAX_BEATS: five beats of 1 with no last flag -> first result 4 with out_beats=4, then a new group starts with the fifth beat.
REQ-042 Backpressure: out_ready=0 for 5 cycles with result held -> in_ready=0 and out_data stable; out_ready=1 together with in_valid=1 -> handshake and accept in the same cycle.
REQ-043 Reset after 2 accumulated beats -> no out_valid; the next group of beat 7 with the last flag -> out_data=7.
